// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin arbiter with port-1 burst lock in front of a single-port data RAM
module dmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_lock,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_BURST);

  logic              last_gnt;
  logic [CNT_W-1:0]  burst_cnt;
  logic              rd_pend0;
  logic              rd_pend1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic              gnt0;
  logic              gnt1;
  logic              locked;

  // Grants are gated by rst_n so they drop the moment reset asserts.
  always_comb begin
    gnt0   = 1'b0;
    gnt1   = 1'b0;
    locked = last_gnt && m1_lock && (burst_cnt < BURST_MAX);
    if (rst_n) begin
      if (m0_req && m1_req) begin
        if (locked || !last_gnt) gnt1 = 1'b1;
        else                     gnt0 = 1'b1;
      end else begin
        gnt0 = m0_req;
        gnt1 = m1_req;
      end
    end
  end

  always_comb begin
    mem_wen   = 1'b0;
    mem_addr  = m0_addr;
    mem_wdata = m0_wdata;
    if (gnt1) begin
      mem_wen   = m1_we;
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
    end else if (gnt0) begin
      mem_wen = m0_we;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt  <= 1'b1;
      burst_cnt <= '0;
      rd_pend0  <= 1'b0;
      rd_pend1  <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      if (gnt0 || gnt1) last_gnt <= gnt1;
      // Only contended locked grants consume the burst budget.
      if (gnt0 || !m1_lock)
        burst_cnt <= '0;
      else if (gnt1 && m0_req && burst_cnt < BURST_MAX)
        burst_cnt <= burst_cnt + 1'b1;
      rd_pend0 <= gnt0 && !m0_we;
      rd_pend1 <= gnt1 && !m1_we;
      if (gnt0 && !m0_we) rdata0 <= mem_rdata;
      if (gnt1 && !m1_we) rdata1 <= mem_rdata;
    end
  end

  assign m0_gnt    = gnt0;
  assign m1_gnt    = gnt1;
  assign m0_rvalid = rd_pend0;
  assign m1_rvalid = rd_pend1;
  assign m0_rdata  = rdata0;
  assign m1_rdata  = rdata1;

endmodule
